cond_exec_stage: RTL and testbench

Execute-side conditional-execution stage fed directly by the instruction decoder. It registers the decoder's control word (the ID/EX boundary), holds the architectural NZCV flags, and evaluates the 4-bit condition field against them. It emits the gated commit strobes for register write, memory write, PC redirect and flag update. It also self-squashes the wrong-path instruction behind a taken PC write.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cond_exec_stage_cond_check.sv | 40 ++++
 rtl/cond_exec_stage.sv | 96 +++++++++
 tb/tb_cond_exec_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the execute-side pipeline stages.
// Condition codes, flag bit positions and the ID/EX control bundle.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [2:0] aluctl_t;

  typedef struct packed {
    logic       valid;
    cond_t      cond;
    logic [1:0] flagW;
    logic       pcs;
    logic       regW;
    logic       memW;
    logic       memtoReg;
    logic       aluSrc;
    logic       branch;
    aluctl_t    aluCtl;
  } id_ex_t;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Condition-field evaluation against the architectural NZCV flags.
// Purely combinational.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] condE,
  input  logic [3:0] flags,
  output logic       condPass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    condPass = 1'b1;
    unique case (cond_t'(condE))
      EQ: condPass = w_z;
      NE: condPass = ~w_z;
      CS: condPass = w_c;
      CC: condPass = ~w_c;
      MI: condPass = w_n;
      PL: condPass = ~w_n;
      VS: condPass = w_v;
      VC: condPass = ~w_v;
      HI: condPass = w_c & ~w_z;
      LS: condPass = ~w_c | w_z;
      GE: condPass = (w_n == w_v);
      LT: condPass = (w_n != w_v);
      GT: condPass = ~w_z & (w_n == w_v);
      LE: condPass = w_z | (w_n != w_v);
      AL: condPass = 1'b1;
      NV: condPass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// ID/EX register, NZCV flags and condition-gated commit strobes.
// A taken PC write squashes the younger instruction behind it.
module cond_exec_stage
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       flush,
  input  logic       validD,
  input  logic [3:0] condD,
  input  logic [1:0] flagWD,
  input  logic       pcsD,
  input  logic       regWD,
  input  logic       memWD,
  input  logic       memtoRegD,
  input  logic       aluSrcD,
  input  logic       branchD,
  input  logic [2:0] aluControlD,
  input  logic [3:0] aluFlags,
  output logic [2:0] aluControlE,
  output logic       aluSrcE,
  output logic       memtoRegE,
  output logic       condExE,
  output logic       regWriteE,
  output logic       memWriteE,
  output logic       pcSrcE,
  output logic [3:0] flags,
  output logic       squashD
);

  id_ex_t     r_e;
  id_ex_t     w_e_nxt;
  logic [3:0] r_flags;
  logic [3:0] w_flags_nxt;
  logic       w_pass;
  logic       w_commit;
  logic       w_unused;

  cond_check u_cond_check (
    .condE    (r_e.cond),
    .flags    (r_flags),
    .condPass (w_pass)
  );

  assign condExE     = r_e.valid & w_pass;
  assign w_commit    = condExE & ~hold;
  assign regWriteE   = r_e.regW & w_commit;
  assign memWriteE   = r_e.memW & w_commit;
  assign pcSrcE      = r_e.pcs & w_commit;
  assign squashD     = pcSrcE;
  assign aluControlE = r_e.aluCtl;
  assign aluSrcE     = r_e.aluSrc;
  assign memtoRegE   = r_e.memtoReg;
  assign flags       = r_flags;
  assign w_unused    = r_e.branch;

  always_comb begin
    w_e_nxt     = r_e;
    w_flags_nxt = r_flags;
    if (!hold) begin
      if (r_e.flagW[1] & condExE)
        w_flags_nxt[FLAG_N:FLAG_Z] = aluFlags[FLAG_N:FLAG_Z];
      if (r_e.flagW[0] & condExE)
        w_flags_nxt[FLAG_C:FLAG_V] = aluFlags[FLAG_C:FLAG_V];
      // pcSrcE already excludes hold, so a held redirect waits
      if (flush | pcSrcE) begin
        w_e_nxt = '0;
      end else begin
        w_e_nxt = '{
          valid:    validD,
          cond:     cond_t'(condD),
          flagW:    flagWD,
          pcs:      pcsD,
          regW:     regWD,
          memW:     memWD,
          memtoReg: memtoRegD,
          aluSrc:   aluSrcD,
          branch:   branchD,
          aluCtl:   aluControlD
        };
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e     <= '0;
      r_flags <= '0;
    end else begin
      r_e     <= w_e_nxt;
      r_flags <= w_flags_nxt;
    end
  end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Scoreboard bench for cond_exec_stage: directed scenarios plus
// random traffic checked against a cycle-level reference model.
module tb_cond_exec_stage;

  typedef struct packed {
    logic       v;
    logic [3:0] cond;
    logic [1:0] fw;
    logic       pcs, rw, mw, m2r, as, br;
    logic [2:0] alu;
  } instr_t;

  typedef struct packed {
    logic [2:0] alu;
    logic       as, m2r, cx, rw, mw, pc, sq;
    logic [3:0] fl;
  } exp_t;

  logic       clk = 0;
  logic       reset, hold, flush, validD;
  logic [3:0] condD;
  logic [1:0] flagWD;
  logic       pcsD, regWD, memWD, memtoRegD, aluSrcD, branchD;
  logic [2:0] aluControlD;
  logic [3:0] aluFlags;
  logic [2:0] aluControlE;
  logic       aluSrcE, memtoRegE, condExE;
  logic       regWriteE, memWriteE, pcSrcE, squashD;
  logic [3:0] flags;

  int n_chk = 0;
  int n_fail = 0;

  exp_t   q[$];
  instr_t m_e;
  logic [3:0] m_fl;

  always #5 clk = ~clk;

  cond_exec_stage dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .validD(validD), .condD(condD), .flagWD(flagWD),
    .pcsD(pcsD), .regWD(regWD), .memWD(memWD),
    .memtoRegD(memtoRegD), .aluSrcD(aluSrcD), .branchD(branchD),
    .aluControlD(aluControlD), .aluFlags(aluFlags),
    .aluControlE(aluControlE), .aluSrcE(aluSrcE),
    .memtoRegE(memtoRegE), .condExE(condExE),
    .regWriteE(regWriteE), .memWriteE(memWriteE),
    .pcSrcE(pcSrcE), .flags(flags), .squashD(squashD)
  );

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pass(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic instr_t mk(logic [3:0] c, logic [1:0] fw,
                                bit pcs, bit rw, bit mw, bit br);
    instr_t w;
    w = '0;
    w.v = 1; w.cond = c; w.fw = fw;
    w.pcs = pcs; w.rw = rw; w.mw = mw; w.br = br;
    w.alu = c[2:0];
    return w;
  endfunction

  // Expected outputs for the cycle just starting, then advance model.
  task automatic step(instr_t w, bit h, bit fl, logic [3:0] af);
    exp_t e;
    bit   cx;
    validD = w.v; condD = w.cond; flagWD = w.fw;
    pcsD = w.pcs; regWD = w.rw; memWD = w.mw;
    memtoRegD = w.m2r; aluSrcD = w.as; branchD = w.br;
    aluControlD = w.alu; hold = h; flush = fl; aluFlags = af;
    cx = m_e.v && pass(m_e.cond, m_fl);
    e.alu = m_e.alu; e.as = m_e.as; e.m2r = m_e.m2r; e.cx = cx;
    e.rw = m_e.rw && cx && !h;
    e.mw = m_e.mw && cx && !h;
    e.pc = m_e.pcs && cx && !h;
    e.sq = e.pc;
    e.fl = m_fl;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!h) begin
      if (cx && m_e.fw[1]) m_fl[3:2] = af[3:2];
      if (cx && m_e.fw[0]) m_fl[1:0] = af[1:0];
      if (fl || e.pc) m_e = '0;
      else m_e = w;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("aluControlE", 8'(aluControlE), 8'(e.alu));
      chk("aluSrcE", 8'(aluSrcE), 8'(e.as));
      chk("memtoRegE", 8'(memtoRegE), 8'(e.m2r));
      chk("condExE", 8'(condExE), 8'(e.cx));
      chk("regWriteE", 8'(regWriteE), 8'(e.rw));
      chk("memWriteE", 8'(memWriteE), 8'(e.mw));
      chk("pcSrcE", 8'(pcSrcE), 8'(e.pc));
      chk("squashD", 8'(squashD), 8'(e.sq));
      chk("flags", 8'(flags), 8'(e.fl));
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_cx"}, 8'(condExE), 8'd0);
    chk({tag, "_rw"}, 8'(regWriteE), 8'd0);
    chk({tag, "_mw"}, 8'(memWriteE), 8'd0);
    chk({tag, "_pc"}, 8'(pcSrcE), 8'd0);
    chk({tag, "_sq"}, 8'(squashD), 8'd0);
    chk({tag, "_fl"}, 8'(flags), 8'd0);
    chk({tag, "_alu"}, 8'(aluControlE), 8'd0);
  endtask

  initial begin
    instr_t adds, nopv, w;
    logic [15:0] r;
    reset = 1; hold = 0; flush = 0; validD = 0; condD = 0;
    flagWD = 0; pcsD = 0; regWD = 0; memWD = 0; memtoRegD = 0;
    aluSrcD = 0; branchD = 0; aluControlD = 0; aluFlags = 0;
    m_e = '0; m_fl = '0;
    adds = mk(4'b1110, 2'b11, 0, 1, 0, 0);
    nopv = mk(4'b1110, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 0;

    // ADDS: writes register, flags 0100 after its E cycle
    step(adds, 0, 0, 4'h0);
    step(nopv, 0, 0, 4'b0100);
    // BEQ taken with Z=1, then squash of the word behind it
    step(mk(4'b0000, 0, 1, 0, 0, 1), 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    // BEQ not taken with Z=0
    step(adds, 0, 0, 4'h0);
    step(mk(4'b0000, 0, 1, 0, 0, 1), 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    // N=1 V=1 Z=0: GT passes, LE store fails
    step(adds, 0, 0, 4'h0);
    step(mk(4'b1100, 0, 0, 1, 0, 0), 0, 0, 4'b1001);
    step(mk(4'b1101, 0, 0, 0, 1, 0), 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    // N,Z-only update leaves C,V untouched
    step(adds, 0, 0, 4'h0);
    step(mk(4'b1110, 2'b10, 0, 1, 0, 0), 0, 0, 4'h0);
    step(nopv, 0, 0, 4'b1011);
    step(nopv, 0, 0, 4'h0);
    // held taken branch: one pulse on release, then a bubble
    step(mk(4'b1110, 0, 1, 0, 0, 1), 0, 0, 4'h0);
    repeat (3) step(nopv, 1, 1, 4'hf);
    step(nopv, 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    step(nopv, 0, 0, 4'h0);
    // reset in the middle of a committing cycle
    step(adds, 0, 0, 4'h0);
    step(adds, 0, 0, 4'b1010);
    chk("pre_rst_rw", 8'(regWriteE), 8'd1);
    #2 reset = 1;
    #1 chk_all_zero("midrst");
    m_e = '0; m_fl = '0;
    @(posedge clk);
    #1 reset = 0;

    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      w = r;
      step(w, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           4'($urandom));
    end

    @(negedge clk);
    #1;
    chk("drain", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
